// File: rtl/phy_rx_serial_to_parallel_if.sv
// Receive-lane signal bundle: serial bit in, recovered byte plus valid/lock flags out.
// The slave modport is the deserializer; the master modport is the bit source / byte consumer.
interface phy_rx_serial_to_parallel_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );
endinterface

// File: rtl/phy_rx_serial_to_parallel.sv
// One PHY receive lane: bit-slides onto the comma code, locks after COM_COUNT aligned commas,
// then presents each recovered non-comma byte for one full byte time (8 clk_32f cycles).
module phy_rx_serial_to_parallel #(
  parameter logic [7:0] COMMA     = 8'hBC,
  parameter int         COM_COUNT = 4
) (
  input  logic                                clk_32f,
  input  logic                                reset,
  phy_rx_serial_to_parallel_if.slave          rx
);

  localparam int         DATA_W  = 8;
  localparam logic [3:0] COM_TGT = 4'(COM_COUNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sr_q;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0]          com_cnt_q, com_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                active_q, active_d;

  logic [DATA_W-1:0]   word;
  logic                boundary;
  logic                comma_hit;
  logic [3:0]          com_cnt_inc;

  function automatic logic is_comma(input logic [DATA_W-1:0] w);
    return (w == COMMA);
  endfunction

  // Candidate word includes the bit being sampled on this edge, so a byte is
  // recognised on the same edge that captures its LSB.
  assign word        = {sr_q[DATA_W-2:0], rx.data_in};
  assign boundary    = (bit_cnt_q == 3'd7);
  assign comma_hit   = is_comma(word);
  assign com_cnt_inc = com_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;

    unique case (state_q)
      SEARCH: begin
        valid_d = 1'b0;
        if (comma_hit) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          state_d   = (COM_TGT == 4'd1) ? ACTIVE : LOCK;
        end
      end

      LOCK: begin
        valid_d   = 1'b0;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (comma_hit) begin
            com_cnt_d = com_cnt_inc;
            if (com_cnt_inc == COM_TGT) begin
              state_d = ACTIVE;
            end
          end else begin
            // A misaligned match from SEARCH lands here; fall back to bit-sliding.
            com_cnt_d = 4'd0;
            state_d   = SEARCH;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (comma_hit) begin
            valid_d = 1'b0;
          end else begin
            data_d  = word;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = SEARCH;
        bit_cnt_d = 3'd0;
        com_cnt_d = 4'd0;
        valid_d   = 1'b0;
      end
    endcase

    active_d = (state_d == ACTIVE);
  end

  // ---- register stage: shift register, control state and output byte ----
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= word;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign rx.data_out  = data_q;
  assign rx.valid_out = valid_q;
  assign rx.active    = active_q;

endmodule

// File: tb/tb_phy_rx_serial_to_parallel.sv
// Directed bench for the receive-lane deserializer: a COM_COUNT=4 lane and a COM_COUNT=1 lane.
module tb_phy_rx_serial_to_parallel;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  int checks = 0;
  int errors = 0;

  phy_rx_serial_to_parallel_if bus  ();
  phy_rx_serial_to_parallel_if bus1 ();

  phy_rx_serial_to_parallel #(.COMMA(8'hBC), .COM_COUNT(4)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .rx      (bus.slave)
  );

  phy_rx_serial_to_parallel #(.COMMA(8'hBC), .COM_COUNT(1)) dut1 (
    .clk_32f (clk_32f),
    .reset   (reset),
    .rx      (bus1.slave)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_bit1(input logic b);
    @(negedge clk_32f);
    bus1.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic check_lane(input string tag, input logic [7:0] d, input logic v, input logic a);
    check({tag, ".data"},   bus.data_out,         d);
    check({tag, ".valid"},  {7'd0, bus.valid_out}, {7'd0, v});
    check({tag, ".active"}, {7'd0, bus.active},    {7'd0, a});
  endtask

  // Sends a byte MSB first; on the 7 edges before its LSB the outputs must still
  // show the previous byte (hd/hv/ha) when chk is set.
  task automatic send_byte(input logic [7:0] b, input bit chk, input string tag,
                           input logic [7:0] hd, input logic hv, input logic ha);
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i]);
      if (chk) check_lane({tag, ".hold"}, hd, hv, ha);
    end
    send_bit(b[0]);
  endtask

  initial begin
    bus.data_in  = 1'b0;
    bus1.data_in = 1'b0;

    // Reset held for 3 edges with random serial input.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'($urandom_range(1, 0)));
      check_lane("reset", 8'h00, 1'b0, 1'b0);
    end
    @(negedge clk_32f);
    reset = 1'b0;

    // Lead-in bits that cannot form a comma with the following stream.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);

    // Lock on the 4th comma.
    send_byte(8'hBC, 1'b0, "lock1", 8'h00, 1'b0, 1'b0);
    check_lane("lock.bc1", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b0, "lock2", 8'h00, 1'b0, 1'b0);
    check_lane("lock.bc2", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b1, "lock3", 8'h00, 1'b0, 1'b0);
    check_lane("lock.bc3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b1, "lock4", 8'h00, 1'b0, 1'b0);
    check_lane("lock.bc4", 8'h00, 1'b0, 1'b1);

    // Data bytes after lock, each held for a full byte time.
    send_byte(8'h00, 1'b1, "d00", 8'h00, 1'b0, 1'b1);
    check_lane("d00", 8'h00, 1'b1, 1'b1);
    send_byte(8'h0E, 1'b1, "d0E", 8'h00, 1'b1, 1'b1);
    check_lane("d0E", 8'h0E, 1'b1, 1'b1);
    send_byte(8'h4E, 1'b1, "d4E", 8'h0E, 1'b1, 1'b1);
    check_lane("d4E", 8'h4E, 1'b1, 1'b1);

    // Idle comma while active: valid drops, data holds.
    send_byte(8'hC0, 1'b1, "idleC0", 8'h4E, 1'b1, 1'b1);
    check_lane("idleC0", 8'hC0, 1'b1, 1'b1);
    send_byte(8'hBC, 1'b1, "idleBC", 8'hC0, 1'b1, 1'b1);
    check_lane("idleBC", 8'hC0, 1'b0, 1'b1);
    send_byte(8'h8A, 1'b1, "idle8A", 8'hC0, 1'b0, 1'b1);
    check_lane("idle8A", 8'h8A, 1'b1, 1'b1);

    // Reset asserted on bit 5 of a data byte while active.
    send_bit(1'b0);
    send_bit(1'b0);
    check_lane("midrst.pre", 8'h8A, 1'b1, 1'b1);
    @(negedge clk_32f);
    reset = 1'b1;
    send_bit(1'b1);
    check_lane("midrst", 8'h00, 1'b0, 1'b0);
    @(negedge clk_32f);
    reset = 1'b0;

    // Broken lock: 2 commas then a data byte returns to search.
    send_byte(8'hBC, 1'b1, "brk1", 8'h00, 1'b0, 1'b0);
    check_lane("brk.bc1", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b1, "brk2", 8'h00, 1'b0, 1'b0);
    check_lane("brk.bc2", 8'h00, 1'b0, 1'b0);
    send_byte(8'h55, 1'b1, "brk55", 8'h00, 1'b0, 1'b0);
    check_lane("brk.55", 8'h00, 1'b0, 1'b0);

    // Re-lock needs 4 fresh commas.
    send_byte(8'hBC, 1'b1, "relk1", 8'h00, 1'b0, 1'b0);
    check_lane("relk.bc1", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b1, "relk2", 8'h00, 1'b0, 1'b0);
    check_lane("relk.bc2", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b1, "relk3", 8'h00, 1'b0, 1'b0);
    check_lane("relk.bc3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b1, "relk4", 8'h00, 1'b0, 1'b0);
    check_lane("relk.bc4", 8'h00, 1'b0, 1'b1);
    send_byte(8'hEE, 1'b1, "relkEE", 8'h00, 1'b0, 1'b1);
    check_lane("relk.EE", 8'hEE, 1'b1, 1'b1);

    // COM_COUNT=1 lane: has only seen zeros so far, so it is still searching.
    check("c1.idle.active", {7'd0, bus1.active}, 8'h00);
    for (int i = 7; i >= 1; i--) begin
      send_bit1(8'hBC >> i);
    end
    check("c1.pre.active", {7'd0, bus1.active}, 8'h00);
    send_bit1(1'b0);
    check("c1.bc.active", {7'd0, bus1.active},    8'h01);
    check("c1.bc.valid",  {7'd0, bus1.valid_out}, 8'h00);
    for (int i = 7; i >= 0; i--) begin
      send_bit1(8'hFD >> i);
    end
    check("c1.FD.data",   bus1.data_out,          8'hFD);
    check("c1.FD.valid",  {7'd0, bus1.valid_out}, 8'h01);
    check("c1.FD.active", {7'd0, bus1.active},    8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
